// File: rtl/riscv_i32_trace_pkg.sv
// Shared types and constants for the RV32 trace packer.
// RISCV_I32_TRACE_PACK_INSTR_EN adds the full instruction word to every packet.
package riscv_i32_trace_pkg;

  localparam int unsigned FifoDepth = 16;
  localparam logic [3:0]  SyncNibble = 4'hA;

`ifdef RISCV_I32_TRACE_PACK_INSTR_EN
  localparam int unsigned MaxWords = 5;
`else
  localparam int unsigned MaxWords = 4;
`endif

  // Header field positions
  localparam int unsigned HdrSyncLsb     = 28;
  localparam int unsigned HdrModeLsb     = 25;
  localparam int unsigned HdrTrapBit     = 24;
  localparam int unsigned HdrBranchBit   = 23;
  localparam int unsigned HdrRfwValidBit = 22;
  localparam int unsigned HdrRetireBit   = 21;
  localparam int unsigned HdrRdLsb       = 16;

  typedef struct packed {
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [2:0]  mode;
    logic [31:0] instr_data;
    logic        rfw_retire;
    logic        rfw_data_valid;
    logic [4:0]  rfw_rd;
    logic [31:0] rfw_data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap;
  } trace_bus_t;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } fifo_entry_t;

  function automatic logic [31:0] make_header(logic [2:0]  mode,
                                              logic        trap,
                                              logic        branch_taken,
                                              logic        rfw_data_valid,
                                              logic        rfw_retire,
                                              logic [4:0]  rfw_rd,
                                              logic [15:0] instr_lo);
    logic [31:0] h;
    h = '0;
    h[HdrSyncLsb +: 4]  = SyncNibble;
    h[HdrModeLsb +: 3]  = mode;
    h[HdrTrapBit]       = trap;
    h[HdrBranchBit]     = branch_taken;
    h[HdrRfwValidBit]   = rfw_data_valid;
    h[HdrRetireBit]     = rfw_retire;
    h[HdrRdLsb +: 5]    = rfw_rd;
    h[15:0]             = instr_lo;
    return h;
  endfunction

endpackage

// File: rtl/riscv_i32_trace_fifo.sv
// 16-entry FIFO of {last, data} accepting a whole packet (up to MaxWr words) per cycle
// and one pop per cycle. The writer guarantees space; this block does not check it.
module riscv_i32_trace_fifo
  import riscv_i32_trace_pkg::*;
#(
  parameter int unsigned MaxWr = MaxWords
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              wr_count,
  input  fifo_entry_t [MaxWr-1:0] wr_data,
  input  logic                    rd_en,
  output fifo_entry_t             rd_data,
  output logic [4:0]              count
);

  fifo_entry_t mem [FifoDepth];
  logic [3:0]  wr_ptr_q, rd_ptr_q;
  logic [4:0]  count_q, count_d;
  logic        pop;

  assign pop     = rd_en && (count_q != 5'd0);
  assign count_d = count_q + 5'(wr_count) - 5'(pop);
  assign count   = count_q;
  // Empty FIFO presents zeros so the head reads clean straight out of reset.
  assign rd_data = (count_q != 5'd0) ? mem[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(MaxWr); i++) begin
      if (3'(i) < wr_count) begin
        mem[wr_ptr_q + 4'(i)] <= wr_data[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + 4'(wr_count);
      rd_ptr_q <= rd_ptr_q + 4'(pop);
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/riscv_i32_trace_pack.sv
// Packs RV32 retirement trace into 2..4 word packets (3..5 with RISCV_I32_TRACE_PACK_INSTR_EN)
// and queues them whole, or drops them whole when they do not fit.
module riscv_i32_trace_pack
  import riscv_i32_trace_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        trace__instr_valid,
  input  logic [31:0] trace__instr_pc,
  input  logic [2:0]  trace__instruction__mode,
  input  logic [31:0] trace__instruction__data,
  input  logic        trace__rfw_retire,
  input  logic        trace__rfw_data_valid,
  input  logic [4:0]  trace__rfw_rd,
  input  logic [31:0] trace__rfw_data,
  input  logic        trace__branch_taken,
  input  logic [31:0] trace__branch_target,
  input  logic        trace__trap,
  input  logic        enable,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [15:0] dropped_count,
  output logic        overflow
);

  trace_bus_t                 trace;
  fifo_entry_t [MaxWords-1:0] words;
  fifo_entry_t                head;
  logic [2:0]                 base_len, pkt_len, tgt_slot, data_slot;
  logic [4:0]                 fifo_count, fifo_free;
  logic                       capture, fits, push, drop;
  logic [15:0]                dropped_q;
  logic                       overflow_q;

  always_comb begin
    trace.instr_valid    = trace__instr_valid;
    trace.instr_pc       = trace__instr_pc;
    trace.mode           = trace__instruction__mode;
    trace.instr_data     = trace__instruction__data;
    trace.rfw_retire     = trace__rfw_retire;
    trace.rfw_data_valid = trace__rfw_data_valid;
    trace.rfw_rd         = trace__rfw_rd;
    trace.rfw_data       = trace__rfw_data;
    trace.branch_taken   = trace__branch_taken;
    trace.branch_target  = trace__branch_target;
    trace.trap           = trace__trap;
  end

`ifdef RISCV_I32_TRACE_PACK_INSTR_EN
  assign base_len = 3'd3;
`else
  assign base_len = 3'd2;
  logic unused_instr_hi;
  assign unused_instr_hi = ^trace.instr_data[31:16];
`endif

  assign tgt_slot  = base_len;
  assign data_slot = base_len + 3'(trace.branch_taken);
  assign pkt_len   = data_slot + 3'(trace.rfw_data_valid);

  always_comb begin
    words = '0;
    words[0].data = make_header(trace.mode, trace.trap, trace.branch_taken,
                                trace.rfw_data_valid, trace.rfw_retire, trace.rfw_rd,
                                trace.instr_data[15:0]);
    words[1].data = trace.instr_pc;
`ifdef RISCV_I32_TRACE_PACK_INSTR_EN
    words[2].data = trace.instr_data;
`endif
    for (int i = 0; i < int'(MaxWords); i++) begin
      if (trace.branch_taken && (3'(i) == tgt_slot)) begin
        words[i].data = trace.branch_target;
      end
      if (trace.rfw_data_valid && (3'(i) == data_slot)) begin
        words[i].data = trace.rfw_data;
      end
      words[i].last = (3'(i) == pkt_len - 3'd1);
    end
  end

  // Space is judged before this cycle's pop, so a same-cycle pop never makes room.
  assign capture   = trace.instr_valid && enable;
  assign fifo_free = 5'(FifoDepth) - fifo_count;
  assign fits      = fifo_free >= {2'b00, pkt_len};
  assign push      = capture && fits;
  assign drop      = capture && !fits;

  riscv_i32_trace_fifo #(
    .MaxWr (MaxWords)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_count (push ? pkt_len : 3'd0),
    .wr_data  (words),
    .rd_en    (out_ready),
    .rd_data  (head),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped_q  <= '0;
      overflow_q <= 1'b0;
    end else if (drop) begin
      dropped_q  <= (dropped_q == 16'hFFFF) ? dropped_q : dropped_q + 16'd1;
      overflow_q <= 1'b1;
    end
  end

  assign out_valid     = fifo_count != 5'd0;
  assign out_data      = head.data;
  assign out_last      = head.last;
  assign dropped_count = dropped_q;
  assign overflow      = overflow_q;

endmodule
